bus_sequencer: RTL and testbench
================================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max wait cycles for bus_ack (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port halt  input  1  stop sequencing after current instruction commits.
REQ-005 SHALL have port pc_addr  input  32  instruction fetch address.
REQ-006 SHALL have ports dm_read_en, dm_write_en, store_byte  input  1 each  data access controls from decode.
REQ-007 SHALL have ports dm_addr, dm_wdata  input  32 each  data address / store data.
REQ-008 SHALL have ports inst, dm_rdata  output  32 each  latched instruction / latched load data.
REQ-009 SHALL have port pc_enable  output  1  one-cycle PC advance / register commit strobe.
REQ-010 SHALL have ports bus_addr, bus_wdata  output  32 each; bus_sel  output  4; bus_read, bus_write  output  1 each.
REQ-011 SHALL have ports bus_ack  input  1; bus_rdata  input  32  shared memory port response.
REQ-012 SHALL have ports instret  output  32  retired count; bus_error  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DECODE, DATA, COMMIT, HALTED, with all outputs registered.
REQ-014 IDLE -> FETCH unconditionally next cycle.
REQ-015 FETCH: bus_read=1, bus_addr=pc_addr, bus_sel=4'b1111; on bus_ack, inst<=bus_rdata, -> DECODE.
REQ-016 DECODE: one settle cycle, no bus request; sample dm_read_en/dm_write_en; either high -> DATA, else -> COMMIT.
REQ-017 DATA: bus_addr=dm_addr; dm_write_en=1 -> bus_write=1 (write wins if both enables high), else bus_read=1; on bus_ack, read latches dm_rdata<=bus_rdata, -> COMMIT.
REQ-018 Stores: store_byte=1 -> bus_sel=4'b0001<<dm_addr[1:0], bus_wdata={4{dm_wdata[7:0]}}; store_byte=0 -> bus_sel=4'b1111, bus_wdata=dm_wdata; loads always full word.
REQ-019 Bus request, bus_addr, bus_sel, bus_wdata SHALL stay stable from assertion until the cycle bus_ack is sampled high; request deasserted the following cycle.
REQ-020 bus_ack SHALL be ignored in IDLE, DECODE, COMMIT, HALTED; ack in same cycle as request assertion is accepted.
REQ-021 COMMIT: pc_enable=1 for exactly one cycle, instret<=instret+1 (wraps 32'hFFFFFFFF -> 0); halt=1 -> HALTED, else -> FETCH.
REQ-022 HALTED: no bus activity, pc_enable=0; halt=0 -> FETCH next cycle.
REQ-023 halt asserted outside COMMIT SHALL not interrupt the in-flight instruction.
REQ-024 Minimum instruction latency with zero-wait ack: 4 cycles without data access, 5 with.
REQ-025 inst and dm_rdata SHALL hold value until next successful latch.

Reset
REQ-026 reset SHALL force state IDLE, inst=0, dm_rdata=0, instret=0, bus_error=0, pc_enable=0, bus_read=0, bus_write=0, bus_sel=0, bus_addr=0, bus_wdata=0, in any state.
REQ-027 reset during an outstanding bus request SHALL drop the request same edge; a late bus_ack is ignored.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN defined: wait counter clears on entry to FETCH/DATA; counter reaching TIMEOUT_CYCLES without bus_ack SHALL drop the request, latch inst=32'h00000013 (FETCH) or dm_rdata=0 (DATA read), set bus_error=1 until reset, and proceed as if acked.
REQ-029 Macro ARB_TIMEOUT_EN undefined: wait indefinitely for bus_ack, no counter, bus_error tied 0.

Verification
REQ-030 Reset release, ack immediate, pc_addr=0x100, bus_rdata=0x00500093, no dm enables -> bus_read at 0x100, inst=0x00500093, pc_enable pulse 4 cycles after IDLE exit, instret=1.
REQ-031 Load: dm_read_en=1, dm_addr=0x200, ack after 3 wait cycles, bus_rdata=0xDEADBEEF -> bus_addr held 0x200 for 4 cycles, dm_rdata=0xDEADBEEF, one pc_enable.
REQ-032 Byte store: store_byte=1, dm_addr=0x203, dm_wdata=0x12345678 -> bus_write=1, bus_sel=4'b1000, bus_wdata=0x78787878.
REQ-033 halt=1 from FETCH onward -> instruction completes, COMMIT, HALTED with no bus requests; halt=0 -> next FETCH next cycle.
REQ-034 instret preloaded 0xFFFFFFFF via 2^32-1 commits (or force) -> next COMMIT gives 0; reset mid-DATA -> all outputs zero next cycle, late ack ignored.
REQ-035 ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ack never -> after 4 wait cycles inst=0x00000013, bus_error=1 sticky, pc_enable pulses.

Source files
------------

// File: rtl/bus_sequencer.sv
// bus_sequencer: sequences instruction fetch, optional data access and commit
// over a single shared memory port (one outstanding request at a time).
//
// Per instruction: FETCH -> DECODE -> [DATA] -> COMMIT -> FETCH (or HALTED).
// All outputs come straight from registers. A request is launched on the edge
// that enters FETCH/DATA and dropped on the edge where bus_ack is sampled.
// pc_enable and the instret increment appear together in the COMMIT cycle.
//
// Ports:
//   clock, reset            - clock and synchronous active-high reset
//   halt                    - park in HALTED after the current commit
//   pc_addr                 - fetch address, sampled when FETCH is entered
//   dm_read_en/dm_write_en  - data access enables, sampled in DECODE
//   store_byte, dm_addr,
//   dm_wdata                - store width/address/data, sampled in DECODE
//   inst, dm_rdata          - latched instruction / latched load data
//   pc_enable               - one-cycle commit strobe
//   bus_addr, bus_wdata,
//   bus_sel, bus_read,
//   bus_write               - shared memory request (held until acked)
//   bus_ack, bus_rdata      - shared memory response
//   instret                 - retired instruction count (wraps)
//   bus_error               - sticky ack-timeout flag
//
// Build option: define ARB_TIMEOUT_EN to add an ack watchdog of
// TIMEOUT_CYCLES cycles; without it the sequencer waits forever for bus_ack
// and bus_error stays 0.

module bus_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        halt,
   input  logic [31:0] pc_addr,
   input  logic        dm_read_en,
   input  logic        dm_write_en,
   input  logic        store_byte,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] inst,
   output logic [31:0] dm_rdata,
   output logic        pc_enable,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_sel,
   output logic        bus_read,
   output logic        bus_write,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic [31:0] instret,
   output logic        bus_error
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_DATA   = 3'd3,
      S_COMMIT = 3'd4,
      S_HALTED = 3'd5
   } state_t;

   localparam logic [31:0] LP_NOP = 32'h0000_0013;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_inst, w_inst_nxt;
   logic [31:0] r_dm_rdata, w_dm_rdata_nxt;
   logic        r_pc_enable, w_pc_enable_nxt;
   logic [31:0] r_bus_addr, w_bus_addr_nxt;
   logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
   logic [3:0]  r_bus_sel, w_bus_sel_nxt;
   logic        r_bus_read, w_bus_read_nxt;
   logic        r_bus_write, w_bus_write_nxt;
   logic [31:0] r_instret, w_instret_nxt;
   logic        w_timeout;
   logic        w_done;
   logic        w_data_req;

   // A request finishes on a real ack or on a watchdog expiry.
   assign w_done     = bus_ack | w_timeout;
   assign w_data_req = dm_read_en | dm_write_en;

`ifdef ARB_TIMEOUT_EN
   logic [31:0] r_wait_cnt;
   logic        r_bus_error;

   // Expiry fires on the last allowed wait cycle so the request is visible
   // for exactly TIMEOUT_CYCLES cycles.
   assign w_timeout = (r_wait_cnt == (TIMEOUT_CYCLES - 32'd1));

   // Wait counter runs only while a request is outstanding; sticky error flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wait_cnt  <= 32'd0;
         r_bus_error <= 1'b0;
      end else begin
         if ((r_state == S_FETCH) || (r_state == S_DATA)) begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
         end else begin
            r_wait_cnt <= 32'd0;
         end
         if (((r_state == S_FETCH) || (r_state == S_DATA)) && w_timeout && !bus_ack) begin
            r_bus_error <= 1'b1;
         end else begin
            r_bus_error <= r_bus_error;
         end
      end
   end

   assign bus_error = r_bus_error;
`else
   // No watchdog: the parameter is referenced only to keep it part of the
   // interface of this build; the expression is constant zero.
   assign w_timeout = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
   assign bus_error = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_inst      <= 32'd0;
         r_dm_rdata  <= 32'd0;
         r_pc_enable <= 1'b0;
         r_bus_addr  <= 32'd0;
         r_bus_wdata <= 32'd0;
         r_bus_sel   <= 4'd0;
         r_bus_read  <= 1'b0;
         r_bus_write <= 1'b0;
         r_instret   <= 32'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_inst      <= w_inst_nxt;
         r_dm_rdata  <= w_dm_rdata_nxt;
         r_pc_enable <= w_pc_enable_nxt;
         r_bus_addr  <= w_bus_addr_nxt;
         r_bus_wdata <= w_bus_wdata_nxt;
         r_bus_sel   <= w_bus_sel_nxt;
         r_bus_read  <= w_bus_read_nxt;
         r_bus_write <= w_bus_write_nxt;
         r_instret   <= w_instret_nxt;
      end
   end

   // Next-state selection.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   w_state_nxt = S_FETCH;
         S_FETCH:  if (w_done) w_state_nxt = S_DECODE; else w_state_nxt = S_FETCH;
         S_DECODE: if (w_data_req) w_state_nxt = S_DATA; else w_state_nxt = S_COMMIT;
         S_DATA:   if (w_done) w_state_nxt = S_COMMIT; else w_state_nxt = S_DATA;
         S_COMMIT: if (halt) w_state_nxt = S_HALTED; else w_state_nxt = S_FETCH;
         S_HALTED: if (halt) w_state_nxt = S_HALTED; else w_state_nxt = S_FETCH;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the output registers; address/select/data hold between
   // requests and are only reloaded when a new request is launched.
   always_comb begin
      w_inst_nxt      = r_inst;
      w_dm_rdata_nxt  = r_dm_rdata;
      w_pc_enable_nxt = 1'b0;
      w_bus_addr_nxt  = r_bus_addr;
      w_bus_wdata_nxt = r_bus_wdata;
      w_bus_sel_nxt   = r_bus_sel;
      w_bus_read_nxt  = r_bus_read;
      w_bus_write_nxt = r_bus_write;
      w_instret_nxt   = r_instret;
      case (r_state)
         S_FETCH: begin
            if (w_done) begin
               w_bus_read_nxt = 1'b0;
               if (bus_ack) w_inst_nxt = bus_rdata; else w_inst_nxt = LP_NOP;
            end else begin
               w_bus_read_nxt = 1'b1;
            end
         end
         S_DECODE: begin
            if (w_data_req) begin
               w_bus_addr_nxt = dm_addr;
               if (dm_write_en) begin
                  w_bus_write_nxt = 1'b1;
                  w_bus_read_nxt  = 1'b0;
                  if (store_byte) begin
                     w_bus_sel_nxt   = 4'b0001 << dm_addr[1:0];
                     w_bus_wdata_nxt = {4{dm_wdata[7:0]}};
                  end else begin
                     w_bus_sel_nxt   = 4'b1111;
                     w_bus_wdata_nxt = dm_wdata;
                  end
               end else begin
                  w_bus_write_nxt = 1'b0;
                  w_bus_read_nxt  = 1'b1;
                  w_bus_sel_nxt   = 4'b1111;
               end
            end else begin
               w_pc_enable_nxt = 1'b1;
               w_instret_nxt   = r_instret + 32'd1;
            end
         end
         S_DATA: begin
            if (w_done) begin
               w_bus_read_nxt  = 1'b0;
               w_bus_write_nxt = 1'b0;
               w_pc_enable_nxt = 1'b1;
               w_instret_nxt   = r_instret + 32'd1;
               if (r_bus_read) begin
                  if (bus_ack) w_dm_rdata_nxt = bus_rdata; else w_dm_rdata_nxt = 32'd0;
               end else begin
                  w_dm_rdata_nxt = r_dm_rdata;
               end
            end else begin
               w_bus_read_nxt  = r_bus_read;
               w_bus_write_nxt = r_bus_write;
            end
         end
         S_IDLE, S_COMMIT, S_HALTED: begin
            // bus_ack is ignored here; only a fetch launch touches the bus.
            if (w_state_nxt == S_FETCH) begin
               w_bus_read_nxt  = 1'b1;
               w_bus_write_nxt = 1'b0;
               w_bus_addr_nxt  = pc_addr;
               w_bus_sel_nxt   = 4'b1111;
            end else begin
               w_bus_read_nxt  = 1'b0;
               w_bus_write_nxt = 1'b0;
            end
         end
         default: begin
            w_bus_read_nxt  = 1'b0;
            w_bus_write_nxt = 1'b0;
         end
      endcase
   end

   assign inst      = r_inst;
   assign dm_rdata  = r_dm_rdata;
   assign pc_enable = r_pc_enable;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_sel   = r_bus_sel;
   assign bus_read  = r_bus_read;
   assign bus_write = r_bus_write;
   assign instret   = r_instret;

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer. An instruction-level model drives
// each instruction phase by phase (fetch, decode, optional data, commit,
// optional halt) and states what the outputs must be in every cycle; a
// compare process checks the DUT against that on each falling edge.
module tb_bus_sequencer;
   localparam int unsigned TO = 4;

   logic        clock = 1'b0;
   logic        reset, halt, dm_read_en, dm_write_en, store_byte, bus_ack;
   logic [31:0] pc_addr, dm_addr, dm_wdata, bus_rdata;
   logic [31:0] inst, dm_rdata, bus_addr, bus_wdata, instret;
   logic [3:0]  bus_sel;
   logic        pc_enable, bus_read, bus_write, bus_error;

   bus_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clock(clock), .reset(reset), .halt(halt), .pc_addr(pc_addr),
      .dm_read_en(dm_read_en), .dm_write_en(dm_write_en), .store_byte(store_byte),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .inst(inst), .dm_rdata(dm_rdata),
      .pc_enable(pc_enable), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_sel(bus_sel), .bus_read(bus_read), .bus_write(bus_write),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .instret(instret), .bus_error(bus_error)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int pe_cyc  = -1;
   int pe_cnt  = 0;
   int a200_cnt = 0;
   bit chk_en  = 1'b0;
   logic [3:0]  seen_sel   = 4'd0;
   logic [31:0] seen_wdata = 32'd0;

   // expected outputs for the current cycle
   logic        e_read = 1'b0, e_write = 1'b0, e_pe = 1'b0, e_err = 1'b0;
   logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_inst = 32'd0, e_rdata = 32'd0, e_instret = 32'd0;
   logic [3:0]  e_sel = 4'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // per-cycle comparison against the model
   always @(negedge clock) begin
      if (chk_en) begin
         chk("bus_read", {31'd0, bus_read}, {31'd0, e_read});
         chk("bus_write", {31'd0, bus_write}, {31'd0, e_write});
         chk("pc_enable", {31'd0, pc_enable}, {31'd0, e_pe});
         chk("inst", inst, e_inst);
         chk("dm_rdata", dm_rdata, e_rdata);
         chk("instret", instret, e_instret);
         chk("bus_error", {31'd0, bus_error}, {31'd0, e_err});
         if (e_read || e_write) begin
            chk("bus_addr", bus_addr, e_addr);
            chk("bus_sel", {28'd0, bus_sel}, {28'd0, e_sel});
         end
         if (e_write) chk("bus_wdata", bus_wdata, e_wdata);
         if (pc_enable && pe_cyc < 0) pe_cyc = cyc;
         if (pc_enable) pe_cnt++;
         if (bus_read && bus_addr == 32'h200) a200_cnt++;
         if (bus_write) begin
            seen_sel   = bus_sel;
            seen_wdata = bus_wdata;
         end
      end
   end

   task automatic rand_dm();
      dm_read_en  = 1'($urandom);
      dm_write_en = 1'($urandom);
      store_byte  = 1'($urandom);
      dm_addr     = $urandom;
      dm_wdata    = $urandom;
   endtask

   // Run one instruction. Entered #1 after the edge of the cycle whose end
   // launches the fetch (IDLE, COMMIT or last HALTED cycle); returns in the
   // same position (COMMIT or last HALTED cycle) or, when abort_at hits,
   // in the IDLE cycle following a reset issued mid-DATA.
   task automatic run_instr(input logic [31:0] pc, input logic [31:0] iw,
                            input bit rd, input bit wr, input bit sb,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rv, input int fd, input int dd,
                            input bit hold_halt, input bit halt_flag, input int hc,
                            input int abort_at);
      int nf;
      int nd;
      bit to_f;
      bit to_d;
      pc_addr = pc; halt = 1'b0;
      bus_ack = 1'($urandom); bus_rdata = $urandom; rand_dm();
      nf = fd + 1; to_f = 1'b0;
`ifdef ARB_TIMEOUT_EN
      if (nf > int'(TO)) begin nf = int'(TO); to_f = 1'b1; end
`endif
      for (int k = 0; k < nf; k++) begin
         @(posedge clock); #1;
         e_read = 1'b1; e_write = 1'b0; e_addr = pc; e_sel = 4'hF; e_pe = 1'b0;
         pc_addr = $urandom;
         halt = hold_halt ? 1'b1 : 1'($urandom);
         bus_ack = (k == fd); bus_rdata = (k == fd) ? iw : $urandom;
         rand_dm();
      end
      // decode cycle
      @(posedge clock); #1;
      e_read = 1'b0; e_write = 1'b0; e_pe = 1'b0;
      e_inst = to_f ? 32'h0000_0013 : iw;
      if (to_f) e_err = 1'b1;
      halt = hold_halt ? 1'b1 : 1'($urandom);
      bus_ack = 1'($urandom); bus_rdata = $urandom;
      dm_read_en = rd; dm_write_en = wr; store_byte = sb; dm_addr = addr; dm_wdata = wd;
      to_d = 1'b0;
      if (rd || wr) begin
         nd = dd + 1;
`ifdef ARB_TIMEOUT_EN
         if (nd > int'(TO)) begin nd = int'(TO); to_d = 1'b1; end
`endif
         for (int k = 0; k < nd; k++) begin
            @(posedge clock); #1;
            e_read = !wr; e_write = wr; e_addr = addr;
            e_sel = (wr && sb) ? (4'b0001 << addr[1:0]) : 4'hF;
            e_wdata = sb ? {4{wd[7:0]}} : wd;
            halt = hold_halt ? 1'b1 : 1'($urandom);
            rand_dm();
            if (k == abort_at) begin
               reset = 1'b1; bus_ack = 1'b1; bus_rdata = $urandom;
               @(posedge clock); #1;
               reset = 1'b0;
               e_read = 1'b0; e_write = 1'b0; e_pe = 1'b0; e_err = 1'b0;
               e_inst = 32'd0; e_rdata = 32'd0; e_instret = 32'd0;
               return;
            end
            bus_ack = (k == dd); bus_rdata = (k == dd) ? rv : $urandom;
         end
      end
      // commit cycle
      @(posedge clock); #1;
      e_read = 1'b0; e_write = 1'b0; e_pe = 1'b1; e_instret = e_instret + 32'd1;
      if (rd && !wr) e_rdata = to_d ? 32'd0 : rv;
      if (to_d) e_err = 1'b1;
      bus_ack = 1'($urandom); bus_rdata = $urandom; halt = halt_flag; rand_dm();
      if (halt_flag) begin
         for (int k = 0; k < hc; k++) begin
            @(posedge clock); #1;
            e_pe = 1'b0;
            halt = (k < hc - 1);
            bus_ack = 1'($urandom); pc_addr = $urandom; rand_dm();
         end
      end
   endtask

   initial begin
      int rel_cyc;
      int pe0;
      reset = 1'b1; halt = 1'b0; pc_addr = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
      dm_read_en = 1'b0; dm_write_en = 1'b0; store_byte = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
      repeat (2) @(posedge clock);
      #1 chk_en = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      rel_cyc = cyc;
      pe_cyc = -1;

      // first instruction: no data access, immediate ack
      run_instr(32'h100, 32'h0050_0093, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
                0, 0, 1'b0, 1'b0, 1, -1);
      chk("t030_inst", inst, 32'h0050_0093);
      chk("t030_instret", instret, 32'd1);
      @(negedge clock); #1;
      // IDLE, FETCH, DECODE, COMMIT: strobe in the fourth cycle after release
      chk("t030_latency", 32'(pe_cyc - rel_cyc), 32'd3);

      // load with three wait cycles
      a200_cnt = 0; pe0 = pe_cnt;
      run_instr(32'h104, 32'h0000_2083, 1'b1, 1'b0, 1'b0, 32'h200, 32'd0, 32'hDEAD_BEEF,
                0, 3, 1'b0, 1'b0, 1, -1);
      chk("t031_rdata", dm_rdata, 32'hDEAD_BEEF);
      @(negedge clock); #1;
      chk("t031_addr_hold", 32'(a200_cnt), 32'd4);
      chk("t031_pe_count", 32'(pe_cnt - pe0), 32'd1);

      // byte store to lane 3
      seen_sel = 4'd0; seen_wdata = 32'd0;
      run_instr(32'h108, 32'h0000_0023, 1'b0, 1'b1, 1'b1, 32'h203, 32'h1234_5678, 32'd0,
                1, 1, 1'b0, 1'b0, 1, -1);
      chk("t032_sel", {28'd0, seen_sel}, 32'h8);
      chk("t032_wdata", seen_wdata, 32'h7878_7878);

      // halt held from fetch onward, released after three halted cycles
      run_instr(32'h10C, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h300, 32'd0, 32'h55AA_55AA,
                1, 0, 1'b1, 1'b1, 3, -1);

      // instret wrap
      force dut.r_instret = 32'hFFFF_FFFF;
      e_instret = 32'hFFFF_FFFF;
      #2 release dut.r_instret;
      run_instr(32'h110, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
                0, 0, 1'b0, 1'b0, 1, -1);
      chk("t034_wrap", instret, 32'd0);

      // reset in the middle of a waited load, then a normal instruction
      run_instr(32'h114, 32'h0000_1003, 1'b1, 1'b0, 1'b0, 32'h400, 32'd0, 32'h0BAD_F00D,
                0, 5, 1'b0, 1'b0, 1, 2);
      chk("t034_rst_addr", bus_addr, 32'd0);
      chk("t034_rst_sel", {28'd0, bus_sel}, 32'd0);
      chk("t034_rst_wdata", bus_wdata, 32'd0);
      chk("t034_rst_inst", inst, 32'd0);
      run_instr(32'h118, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
                2, 0, 1'b0, 1'b0, 1, -1);
      chk("t034_after_rst", instret, 32'd1);

`ifdef ARB_TIMEOUT_EN
      // fetch never acked: watchdog substitutes a NOP and flags the error
      run_instr(32'h11C, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
                20, 0, 1'b0, 1'b0, 1, -1);
      chk("t035_inst", inst, 32'h0000_0013);
      chk("t035_err", {31'd0, bus_error}, 32'd1);
`endif

      // randomized instruction stream
      for (int i = 0; i < 40; i++) begin
         bit rd_r;
         bit wr_r;
         bit hf_r;
         rd_r = 1'($urandom);
         wr_r = ($urandom_range(0, 2) == 0);
         hf_r = ($urandom_range(0, 4) == 0);
         run_instr($urandom & 32'hFFFF_FFFC, $urandom, rd_r, wr_r, 1'($urandom),
                   $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   1'b0, hf_r, int'($urandom_range(1, 3)), -1);
      end
`ifndef ARB_TIMEOUT_EN
      chk("no_error", {31'd0, bus_error}, 32'd0);
`endif
      @(negedge clock); #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
